// File: rtl/act8_demux_1by4.sv
// 1-to-4 single-bit demultiplexer with a registered output copy and
// per-channel saturating counters of routed '1' bits.
module act8_demux_1by4 #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s1,
  input  logic             s0,
  input  logic             d,
  input  logic             clr,
  output logic             y0,
  output logic             y1,
  output logic             y2,
  output logic             y3,
  output logic             q0,
  output logic             q1,
  output logic             q2,
  output logic             q3,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2,
  output logic [CNT_W-1:0] cnt3
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [3:0]       w_y;
  logic [3:0]       r_q;
  logic [CNT_W-1:0] r_cnt [4];

  // Pure dataflow decode: independent of clock and reset.
  assign w_y[0] = ~s1 & ~s0 & d;
  assign w_y[1] = ~s1 &  s0 & d;
  assign w_y[2] =  s1 & ~s0 & d;
  assign w_y[3] =  s1 &  s0 & d;

  assign {y3, y2, y1, y0} = w_y;
  assign {q3, q2, q1, q0} = r_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else begin
      r_q <= w_y;
    end
  end

  // NOTE: the counter array is only four flop words, not a RAM, so it is
  // safe and intended to clear it in the async reset branch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) r_cnt[k] <= '0;
    end else if (clr) begin
      for (int k = 0; k < 4; k++) r_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (w_y[k] && (r_cnt[k] != CNT_MAX)) r_cnt[k] <= r_cnt[k] + CNT_ONE;
      end
    end
  end

  assign cnt0 = r_cnt[0];
  assign cnt1 = r_cnt[1];
  assign cnt2 = r_cnt[2];
  assign cnt3 = r_cnt[3];

endmodule

// File: tb/tb_act8_demux_1by4.sv
// Self-checking bench: an 8-bit-counter instance and a 2-bit-counter instance
// share stimulus; a scoreboard queue holds expected post-edge state.
module tb_act8_demux_1by4;

  logic clk = 1'b0;
  logic rst_n, s1, s0, d, clr;

  logic y0a, y1a, y2a, y3a, q0a, q1a, q2a, q3a;
  logic [7:0] c0a, c1a, c2a, c3a;
  logic y0b, y1b, y2b, y3b, q0b, q1b, q2b, q3b;
  logic [1:0] c0b, c1b, c2b, c3b;

  always #5 clk = ~clk;

  act8_demux_1by4 #(.CNT_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .s1(s1), .s0(s0), .d(d), .clr(clr),
    .y0(y0a), .y1(y1a), .y2(y2a), .y3(y3a),
    .q0(q0a), .q1(q1a), .q2(q2a), .q3(q3a),
    .cnt0(c0a), .cnt1(c1a), .cnt2(c2a), .cnt3(c3a)
  );

  act8_demux_1by4 #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .s1(s1), .s0(s0), .d(d), .clr(clr),
    .y0(y0b), .y1(y1b), .y2(y2b), .y3(y3b),
    .q0(q0b), .q1(q1b), .q2(q2b), .q3(q3b),
    .cnt0(c0b), .cnt1(c1b), .cnt2(c2b), .cnt3(c3b)
  );

  logic [3:0]      ya, yb, qa, qb;
  logic [3:0][7:0] ca;
  logic [3:0][1:0] cb;
  assign ya = {y3a, y2a, y1a, y0a};
  assign yb = {y3b, y2b, y1b, y0b};
  assign qa = {q3a, q2a, q1a, q0a};
  assign qb = {q3b, q2b, q1b, q0b};
  assign ca = {c3a, c2a, c1a, c0a};
  assign cb = {c3b, c2b, c1b, c0b};

  typedef struct packed {
    logic [3:0]      q;
    logic [3:0][7:0] c8;
    logic [3:0][1:0] c2;
  } exp_t;

  exp_t exp_q[$];
  exp_t m;  // reference model state
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] model_y(input logic [1:0] sel, input logic din);
    logic [3:0] r;
    r = '0;
    if (din) r[sel] = 1'b1;
    return r;
  endfunction

  task automatic check_y(input string tag);
    logic [3:0] ey;
    ey = model_y({s1, s0}, d);
    check({tag, "_y8"}, 32'(ya), 32'(ey));
    check({tag, "_y2"}, 32'(yb), 32'(ey));
    check({tag, "_onehot"}, 32'($countones(ya) <= 1), 32'd1);
  endtask

  // Drive one cycle of stimulus, push the expected post-edge state, then
  // pop it and compare once the DUT has taken the edge.
  task automatic step(input logic [1:0] sel, input logic din, input logic dclr);
    logic [3:0] ey;
    exp_t e;
    @(negedge clk);
    {s1, s0} = sel;
    d = din;
    clr = dclr;
    #1;
    check_y("pre");
    check("q_hold8", 32'(qa), 32'(m.q));
    ey = model_y(sel, din);
    m.q = ey;
    for (int k = 0; k < 4; k++) begin
      if (dclr) begin
        m.c8[k] = '0;
        m.c2[k] = '0;
      end else if (ey[k]) begin
        if (m.c8[k] != 8'hFF) m.c8[k] = m.c8[k] + 8'd1;
        if (m.c2[k] != 2'h3)  m.c2[k] = m.c2[k] + 2'd1;
      end
    end
    exp_q.push_back(m);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("q8", 32'(qa), 32'(e.q));
    check("q2", 32'(qb), 32'(e.q));
    check("cnt8", ca, e.c8);
    check("cnt2", 32'(cb), 32'(e.c2));
    check("q_onehot", 32'($countones(qa) <= 1), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    m = '0;
    rst_n = 1'b0; clr = 1'b0; {s1, s0} = 2'b00; d = 1'b0;
    #2;
    check("rst_q8", 32'(qa), 32'd0);
    check("rst_cnt8", ca, 32'd0);
    check("rst_cnt2", 32'(cb), 32'd0);

    // Combinational sweep while in reset: y follows inputs regardless.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      {s1, s0, d} = v;
      #1;
      check_y("sweep");
    end
    check("sweep_q_in_rst", 32'(qa), 32'd0);

    @(negedge clk);
    d = 1'b0;
    rst_n = 1'b1;

    // Register latency on channel 2.
    step(2'b10, 1'b1, 1'b0);
    check("lat_q2", 32'(q2a), 32'd1);
    check("lat_q_others", 32'({q3a, q1a, q0a}), 32'd0);
    step(2'b10, 1'b0, 1'b0);
    check("lat_q2_back", 32'(qa), 32'd0);

    // Counting on channel 1, then clear beats increment.
    step(2'b00, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(2'b01, 1'b1, 1'b0);
    check("cnt1_is5", 32'(c1a), 32'd5);
    check("cnt_others0", 32'({c3a, c2a, c0a}), 32'd0);
    step(2'b01, 1'b1, 1'b1);
    check("cnt1_clr", 32'(c1a), 32'd0);

    // Saturation on the 2-bit instance, channel 3.
    begin
      logic [1:0] sat_tbl [6];
      sat_tbl = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
      for (int i = 0; i < 6; i++) begin
        step(2'b11, 1'b1, 1'b0);
        check("sat_cnt3", 32'(c3b), 32'(sat_tbl[i]));
      end
      check("nosat_cnt3_w8", 32'(c3a), 32'd6);
    end

    // Asynchronous reset mid-cycle with counters nonzero.
    @(negedge clk);
    {s1, s0} = 2'b11; d = 1'b1; clr = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_q8", 32'(qa), 32'd0);
    check("arst_cnt8", ca, 32'd0);
    check("arst_cnt2", 32'(cb), 32'd0);
    check_y("arst");
    m = '0;
    @(posedge clk);
    #1;
    check("arst_hold_cnt8", ca, 32'd0);
    @(negedge clk);
    d = 1'b0;
    rst_n = 1'b1;

    // Random traffic with occasional clears.
    for (int i = 0; i < 1000; i++) begin
      step(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 63) == 0));
    end

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/act8_demux_1by4.md
Name: act8_demux_1by4

Overview:
1-to-4 single-bit demultiplexer. The 2-bit select {s1,s0} routes data input d to exactly one of four outputs; the other three are driven 0. The block provides:
- a pure combinational (dataflow) output set;
- a registered copy of that output set;
- per-channel saturating counters of routed '1' bits, for downstream diagnostic and status logic.

Parameters:
CNT_W, 8, width of each per-channel routed-one counter (legal range 2..32)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
s1  input  1  select MSB
s0  input  1  select LSB
d  input  1  data input to be routed
clr  input  1  synchronous clear of all counters (active high)
y0  output  1  combinational channel 0 (sel=00)
y1  output  1  combinational channel 1 (sel=01)
y2  output  1  combinational channel 2 (sel=10)
y3  output  1  combinational channel 3 (sel=11)
q0  output  1  registered y0
q1  output  1  registered y1
q2  output  1  registered y2
q3  output  1  registered y3
cnt0  output  CNT_W  count of cycles with y0=1
cnt1  output  CNT_W  count of cycles with y1=1
cnt2  output  CNT_W  count of cycles with y2=1
cnt3  output  CNT_W  count of cycles with y3=1

Behaviour:
- sel = {s1,s0}.
- Combinational outputs, zero latency, no clock dependence:
  - y0 = ~s1 & ~s0 & d
  - y1 = ~s1 & s0 & d
  - y2 = s1 & ~s0 & d
  - y3 = s1 & s0 & d
- At most one of y0..y3 is 1 at any time. All are 0 when d=0, regardless of sel.
- Combinational outputs are unaffected by rst_n.
- Reset: while rst_n=0, q0..q3=0 and cnt0..cnt3=0 immediately (asynchronous assertion). Deassertion is sampled at the next rising clk edge.
- Registered outputs: qk <= yk on every rising clk edge. One-cycle latency. They remain one-hot-or-zero.
- Counters, evaluated at each rising edge when rst_n=1:
  - If clr=1: all cnt <= 0. clr has priority over increment in the same cycle.
  - Else if yk=1 and cntk < 2^CNT_W-1: cntk <= cntk+1.
  - At all-ones, cntk holds (saturates, no wrap).
  - At most one counter increments per cycle.
- A select or data change mid-cycle affects only y*. q* and cnt* reflect the values present at the clock edge.
- X/Z on inputs is not handled; inputs are required to be driven.
- No handshake. d is sampled every cycle.

Test Plan:
1. Combinational sweep, {s1,s0,d} = 0..7, 1 time unit each:
   - d=0 entries -> all y=0.
   - 001 -> y0=1
   - 011 -> y1=1
   - 101 -> y2=1
   - 111 -> y3=1
   - In each case the other y outputs are 0.
2. Reset: drive rst_n=0 mid-run with counters nonzero -> q*=0 and cnt*=0 without waiting for clk. y* still follows the inputs.
3. Register latency: sel=10, d=1 held one cycle, then d=0 -> q2=1 exactly one cycle after y2=1, then returns to 0; q0, q1, q3 stay 0.
4. Counting: sel=01, d=1 for 5 cycles -> cnt1=5, other counters 0. Then clr=1 with d=1 for one cycle -> cnt1=0 (clr wins).
5. Saturation with CNT_W=2: sel=11, d=1 for 6 cycles -> cnt3 reads 1, 2, 3, 3, 3 and holds at 3.
6. Random select/data for 1000 cycles: a scoreboard checks one-hot-or-zero on y and q, q equal to y delayed by one cycle, and counters matching a reference model.
